quan_e_regs_v3: RTL and testbench
=================================

Name: quan_e_regs_v3

Overview:
- Parametrised, double-buffered E-scale (dequantisation scale) register file feeding the conv core quantisation stage.
- Receives E words from the on-chip buffer through a valid/ready stream into a shadow bank while the active bank serves per-row reads to the output stage.
- A commit handshake swaps the banks, so tile N+1 scales load while tile N computes.
- Supports arbitrary SA row count, rows per SA, E width and word width.

Parameters:
- SA_ROW_NUM, 4, SA rows in the conv core (channels per read)
- ROW_NUM_IN_SA, 16, rows per SA (valid read index range 1..ROW_NUM_IN_SA)
- E_WIDTH, 16, width of one E value
- PE_PARALLEL_18, 2, E values per set in mode 1
- E_WORD_WIDTH, 512, input word width
- (derived) E_SET_WIDTH = E_WIDTH*PE_PARALLEL_18; SETS_TOTAL = SA_ROW_NUM*ROW_NUM_IN_SA; PER_BEAT0 = E_WORD_WIDTH/E_WIDTH; PER_BEAT1 = E_WORD_WIDTH/E_SET_WIDTH

Ports:
- clk  in  1  clock
- rst  in  1  reset
- mode  in  4  0: one E per set, zero-extended to E_SET_WIDTH; 1: full E sets; other values: treated as mode 1
- load_start  in  1  pulse; begin filling the shadow bank
- load_num_sets  in  8  number of sets to load; sampled with load_start
- in_valid  in  1  E word valid
- in_ready  out  1  block accepts E word
- in_word  in  E_WORD_WIDTH  packed E values, LSB first
- load_done  out  1  one-cycle pulse; shadow bank complete
- shadow_full  out  1  shadow bank loaded and not yet committed
- swap  in  1  commit shadow bank to active
- rd_en  in  1  read request
- rd_row_idx  in  6  output SA row index, 1-based
- out_valid  out  1  out_sets valid this cycle
- out_sets  out  SA_ROW_NUM*E_SET_WIDTH  {row SA_ROW_NUM set, ..., row 1 set}

Behaviour:
- Reset is asynchronous and active-high on rst; clock is clk.
- Reset values: state IDLE, active bank 0, shadow_full 0, in_ready 0, load_done 0, out_valid 0, out_sets 0. Bank contents are not reset.
- Set k (0-based) is stored at bank[k]. Channel r (0-based) at row idx i reads bank[r*ROW_NUM_IN_SA + i-1].
- FSM states: IDLE, LOAD, DONE.
  - IDLE: load_start with N = min(load_num_sets, SETS_TOTAL). If N = 0, go to DONE. Otherwise clear shadow_full, latch mode, set write pointer wp = 0, and go to LOAD.
  - LOAD: in_ready = 1. On in_valid && in_ready, write PER_BEAT(mode) consecutive sets starting at wp. Only sets with index < N are written; sets beyond N in the last beat are discarded. wp advances by PER_BEAT. When wp reaches or passes N, go to DONE.
  - DONE: load_done = 1 for one cycle; shadow_full <= 1; return to IDLE.
- Beats required = ceil(N/PER_BEAT). Mode 0 takes E_WIDTH slices; mode 1 takes E_SET_WIDTH slices.
- load_start is ignored in LOAD and DONE.
- A load_start in IDLE while shadow_full = 1 restarts the load and overwrites the shadow bank.
- Swap: swap && shadow_full toggles the active bank and clears shadow_full at the same edge. swap without shadow_full is ignored. swap in the same cycle as the DONE→IDLE transition is ignored; shadow_full rises one cycle later.
- Read latency is 1 cycle.
  - rd_en with 1 ≤ rd_row_idx ≤ ROW_NUM_IN_SA: next cycle out_sets = active bank sets and out_valid = 1.
  - Invalid index or rd_en = 0: out_valid = 0 and out_sets holds its value.
- rd_en and swap in the same cycle: the read returns the pre-swap bank.
- Reads never see the shadow bank. A load in progress never disturbs active data.
- Reset mid-LOAD: returns to IDLE with shadow_full 0. The partial shadow contents are discarded logically.

Optional Feature:
- QUAN_E_OOB_ERR_EN defined:
  - Adds output err_oob (1 bit, sticky, reset 0).
  - err_oob sets on rd_en with an invalid rd_row_idx, on load_num_sets > SETS_TOTAL at load_start, or on swap without shadow_full.
  - err_oob clears only on reset.
- Without the macro: no port and no logic; such events are silently ignored or clamped as above.

Test Plan:
- Mode 0, N=64, 2 beats with word0 E[k]=k, word1 E[k]=32+k, swap, then rd idx 1 → out_sets = {0x0030,0x0020,0x0010,0x0000}, zero-extended to 32 b each, out_valid 1 cycle after rd_en.
- Mode 1, N=64, 4 beats with set value 0xA0000+k, in_valid toggling every other cycle, swap, rd idx 16 → {0xA003F,0xA002F,0xA001F,0xA000F}. load_done pulses exactly once, after the 4th accepted beat.
- Double buffer: load bank A and swap; load bank B with different values while rd_en is issued every cycle at idx 5 → reads return A data until swap. The rd_en issued in the swap cycle still returns A; the rd_en issued in the next cycle returns B.
- Partial load: mode 1, N=20, 2 beats, second beat all 0xFFFFFFFF → sets 16..19 written, sets 20..31 keep their prior values.
- Boundaries: rd idx 0 or 17 → out_valid 0 and out_sets unchanged. swap with shadow_full 0 → no bank change. load_num_sets=0 → load_done after 1 cycle with no beats consumed. load_num_sets=100 → treated as 64.
- rst asserted mid-LOAD after 1 of 4 beats → in_ready 0, shadow_full 0 and outputs 0 immediately without a clock edge; a subsequent full load and swap reads back correct data. With QUAN_E_OOB_ERR_EN defined, rd idx 17 sets err_oob.

Source files
------------

// File: rtl/quan_e_regs_v3.sv
// Double-buffered E-scale register file: stream loads fill the shadow bank, swap commits it, rows read from the active bank.
// Define QUAN_E_OOB_ERR_EN to add the sticky err_oob output for out-of-range reads, oversized loads and empty swaps.
module quan_e_regs_v3 #(
   parameter int SA_ROW_NUM     = 4,
   parameter int ROW_NUM_IN_SA  = 16,
   parameter int E_WIDTH        = 16,
   parameter int PE_PARALLEL_18 = 2,
   parameter int E_WORD_WIDTH   = 512,
   localparam int E_SET_WIDTH   = E_WIDTH * PE_PARALLEL_18
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [3:0]                       mode,
   input  logic                             load_start,
   input  logic [7:0]                       load_num_sets,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [E_WORD_WIDTH-1:0]          in_word,
   output logic                             load_done,
   output logic                             shadow_full,
   input  logic                             swap,
   input  logic                             rd_en,
   input  logic [5:0]                       rd_row_idx,
   output logic                             out_valid,
`ifdef QUAN_E_OOB_ERR_EN
   output logic                             err_oob,
`endif
   output logic [SA_ROW_NUM*E_SET_WIDTH-1:0] out_sets
);

   // state  | meaning
   // S_IDLE | waiting for load_start; swaps and reads served
   // S_LOAD | accepting E words into the shadow bank
   // S_DONE | shadow bank complete, load_done high for this cycle

   localparam int SETS_TOTAL = SA_ROW_NUM * ROW_NUM_IN_SA;
   localparam int PER_BEAT0  = E_WORD_WIDTH / E_WIDTH;
   localparam int PER_BEAT1  = E_WORD_WIDTH / E_SET_WIDTH;
   localparam int WP_W       = $clog2(SETS_TOTAL + PER_BEAT0 + 1);
   localparam int ADDR_W     = $clog2(SETS_TOTAL);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

   state_t             state;
   logic               active;
   logic               mode0_q;
   logic [WP_W-1:0]    wp;
   logic [WP_W-1:0]    n_sets;
   logic [WP_W-1:0]    n_clamp;
   logic [WP_W-1:0]    pb_w;
   logic               shadow_sel;
   logic               rd_idx_ok;
   logic               swap_ok;

   logic [E_SET_WIDTH-1:0] bank [2][SETS_TOTAL];

   always_comb begin
      n_clamp    = (int'(load_num_sets) > SETS_TOTAL) ? WP_W'(SETS_TOTAL) : WP_W'(load_num_sets);
      pb_w       = mode0_q ? WP_W'(PER_BEAT0) : WP_W'(PER_BEAT1);
      shadow_sel = ~active;
      rd_idx_ok  = (rd_row_idx != 6'd0) && (int'(rd_row_idx) <= ROW_NUM_IN_SA);
      // shadow_full only becomes visible after DONE, so a swap in DONE never commits
      swap_ok    = swap && shadow_full && (state != S_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         active      <= 1'b0;
         shadow_full <= 1'b0;
         in_ready    <= 1'b0;
         load_done   <= 1'b0;
         mode0_q     <= 1'b0;
         wp          <= '0;
         n_sets      <= '0;
      end else begin
         load_done <= 1'b0;
         if (swap_ok) begin
            active      <= ~active;
            shadow_full <= 1'b0;
         end
         case (state)
            S_IDLE: begin
               if (load_start) begin
                  mode0_q <= (mode == 4'd0);
                  wp      <= '0;
                  n_sets  <= n_clamp;
                  if (n_clamp == '0) begin
                     state     <= S_DONE;
                     load_done <= 1'b1;
                  end else begin
                     shadow_full <= 1'b0;
                     in_ready    <= 1'b1;
                     state       <= S_LOAD;
                  end
               end
            end
            S_LOAD: begin
               if (in_valid) begin
                  wp <= wp + pb_w;
                  if (int'(wp) + int'(pb_w) >= int'(n_sets)) begin
                     in_ready  <= 1'b0;
                     load_done <= 1'b1;
                     state     <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               shadow_full <= 1'b1;
               state       <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Sets past n_sets in the final beat are dropped so stale shadow data survives.
   always_ff @(posedge clk) begin
      if (in_valid && in_ready) begin
         if (mode0_q) begin
            for (int j = 0; j < PER_BEAT0; j++) begin
               if (int'(wp) + j < int'(n_sets))
                  bank[shadow_sel][ADDR_W'(int'(wp) + j)] <=
                     E_SET_WIDTH'(in_word[j*E_WIDTH +: E_WIDTH]);
            end
         end else begin
            for (int j = 0; j < PER_BEAT1; j++) begin
               if (int'(wp) + j < int'(n_sets))
                  bank[shadow_sel][ADDR_W'(int'(wp) + j)] <=
                     in_word[j*E_SET_WIDTH +: E_SET_WIDTH];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_sets  <= '0;
      end else if (rd_en && rd_idx_ok) begin
         out_valid <= 1'b1;
         for (int r = 0; r < SA_ROW_NUM; r++)
            out_sets[r*E_SET_WIDTH +: E_SET_WIDTH] <=
               bank[active][ADDR_W'(r*ROW_NUM_IN_SA + int'(rd_row_idx) - 1)];
      end else begin
         out_valid <= 1'b0;
      end
   end

`ifdef QUAN_E_OOB_ERR_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         err_oob <= 1'b0;
      else if ((rd_en && !rd_idx_ok) ||
               (state == S_IDLE && load_start && int'(load_num_sets) > SETS_TOTAL) ||
               (swap && !shadow_full))
         err_oob <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_quan_e_regs_v3.sv
// Bench for quan_e_regs_v3: random E loads checked against a two-bank array model of the scale register file.
module tb_quan_e_regs_v3;
   localparam int SA = 4, ROWS = 16, EW = 16, SW = 32, WW = 512, TOT = 64;

   logic clk = 1'b0;
   logic rst;
   logic [3:0] mode;
   logic load_start;
   logic [7:0] load_num_sets;
   logic in_valid;
   logic in_ready;
   logic [WW-1:0] in_word;
   logic load_done, shadow_full, swap, rd_en;
   logic [5:0] rd_row_idx;
   logic out_valid;
   logic [SA*SW-1:0] out_sets;
`ifdef QUAN_E_OOB_ERR_EN
   logic err_oob;
`endif

   quan_e_regs_v3 dut (
      .clk(clk), .rst(rst), .mode(mode), .load_start(load_start),
      .load_num_sets(load_num_sets), .in_valid(in_valid), .in_ready(in_ready),
      .in_word(in_word), .load_done(load_done), .shadow_full(shadow_full),
      .swap(swap), .rd_en(rd_en), .rd_row_idx(rd_row_idx), .out_valid(out_valid),
`ifdef QUAN_E_OOB_ERR_EN
      .err_oob(err_oob),
`endif
      .out_sets(out_sets)
   );

   always #5 clk = ~clk;

   logic [SW-1:0]    mb [2][TOT];
   int               m_act;
   bit               m_full;
   logic [SA*SW-1:0] m_out;
   int               checks, errors;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [SA*SW-1:0] exp_row(input int idx);
      logic [SA*SW-1:0] e;
      for (int r = 0; r < SA; r++) e[r*SW +: SW] = mb[m_act][r*ROWS + idx - 1];
      return e;
   endfunction

   // pat 0: random; 1: index pattern; 2: index pattern in beat 0, all ones afterwards
   task automatic do_load(input int m, input int nreq, input int pat, input bit gaps);
      int n, pb, beats, g;
      logic [WW-1:0] w;
      logic [SW-1:0] v;
      n     = (nreq > TOT) ? TOT : nreq;
      pb    = (m == 0) ? 32 : 16;
      beats = (n + pb - 1) / pb;
      mode = 4'(m); load_num_sets = 8'(nreq); load_start = 1'b1;
      tick();
      load_start = 1'b0;
      if (n == 0) begin
         chk("ld_done_n0", load_done, 1'b1);
         chk("n0_no_ready", in_ready, 1'b0);
      end else begin
         chk("in_ready_load", in_ready, 1'b1);
         m_full = 1'b0;
         for (int b = 0; b < beats; b++) begin
            if (gaps && b > 0) begin
               tick();
               chk("ld_done_gap", load_done, 1'b0);
            end
            w = '0;
            for (int j = 0; j < pb; j++) begin
               g = b*pb + j;
               if (pat == 0) v = $urandom;
               else if (pat == 2 && b > 0) v = '1;
               else v = (m == 0) ? SW'(g) : SW'(32'hA0000 + g);
               if (m == 0) begin
                  w[j*EW +: EW] = v[EW-1:0];
                  if (g < n) mb[1-m_act][g] = {16'h0, v[EW-1:0]};
               end else begin
                  w[j*SW +: SW] = v;
                  if (g < n) mb[1-m_act][g] = v;
               end
            end
            in_word = w; in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            chk($sformatf("ld_done_beat%0d", b), load_done, (b == beats-1));
         end
      end
      tick();
      chk("ld_done_clr", load_done, 1'b0);
      chk("full_set", shadow_full, 1'b1);
      m_full = 1'b1;
   endtask

   task automatic do_swap();
      swap = 1'b1;
      tick();
      swap = 1'b0;
      if (m_full) begin
         m_act  = 1 - m_act;
         m_full = 1'b0;
      end
      chk("swap_full", shadow_full, m_full);
   endtask

   task automatic do_read(input int idx);
      bit ok;
      ok = (idx >= 1) && (idx <= ROWS);
      rd_en = 1'b1; rd_row_idx = 6'(idx);
      tick();
      rd_en = 1'b0;
      if (ok) m_out = exp_row(idx);
      chk($sformatf("rd_valid_%0d", idx), out_valid, ok);
      chk($sformatf("rd_data_%0d", idx), out_sets, m_out);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      logic [SA*SW-1:0] pend;
      checks = 0; errors = 0; m_act = 0; m_full = 1'b0; m_out = '0;
      rst = 1'b1; mode = '0; load_start = 1'b0; load_num_sets = '0; in_valid = 1'b0;
      in_word = '0; swap = 1'b0; rd_en = 1'b0; rd_row_idx = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_load_done", load_done, 1'b0);
      chk("rst_full", shadow_full, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_sets", out_sets, '0);
`ifdef QUAN_E_OOB_ERR_EN
      chk("rst_err_oob", err_oob, 1'b0);
`endif
      tick();

      do_load(0, 64, 1, 1'b0);
      do_swap();
      do_read(1);
      chk("mode0_lit", out_sets, 128'h00000030_00000020_00000010_00000000);

      do_load(1, 64, 1, 1'b1);
      do_swap();
      do_read(16);
      chk("mode1_lit", out_sets, 128'h000A003F_000A002F_000A001F_000A000F);

      // reads of the active bank while the shadow bank fills
      fork
         do_load(1, 64, 0, 1'b1);
         begin
            for (int c = 0; c < 10; c++) begin
               rd_en = 1'b1; rd_row_idx = 6'd5; pend = exp_row(5);
               tick();
               chk("db_rd_valid", out_valid, 1'b1);
               chk("db_rd_A", out_sets, pend);
            end
            rd_en = 1'b0;
            m_out = pend;
         end
      join
      rd_en = 1'b1; rd_row_idx = 6'd5; swap = 1'b1; pend = exp_row(5);
      tick();
      swap = 1'b0;
      chk("db_swap_cycle_A", out_sets, pend);
      if (m_full) begin m_act = 1 - m_act; m_full = 1'b0; end
      pend = exp_row(5);
      tick();
      rd_en = 1'b0;
      chk("db_after_B", out_sets, pend);
      chk("db_after_valid", out_valid, 1'b1);
      m_out = pend;

      do_load(1, 20, 2, 1'b0);
      do_swap();
      for (int i = 1; i <= ROWS; i++) do_read(i);
      do_read(2);
      chk("partial_ones", out_sets[63:32], 32'hFFFFFFFF);
      do_read(5);
      chk("partial_keep", out_sets[63:32], 32'h000A0014);

      do_read(0);
      do_read(17);
      do_swap();
      do_read(3);
      do_load(1, 0, 0, 1'b0);
      do_load(1, 100, 0, 1'b0);
      do_swap();
      do_read(1);
      do_read(16);

      mode = 4'd1; load_num_sets = 8'd64; load_start = 1'b1;
      tick();
      load_start = 1'b0;
      m_full = 1'b0;
      in_word = {WW/32{$urandom}};
      for (int j = 0; j < 16; j++) mb[1-m_act][j] = in_word[j*SW +: SW];
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_ready", in_ready, 1'b0);
      chk("mid_rst_full", shadow_full, 1'b0);
      chk("mid_rst_valid", out_valid, 1'b0);
      chk("mid_rst_sets", out_sets, '0);
      chk("mid_rst_done", load_done, 1'b0);
      m_act = 0; m_full = 1'b0; m_out = '0;
      tick();
      rst = 1'b0;
      tick();
      do_load(0, 64, 0, 1'b0);
      do_swap();
      do_read(7);
      do_read(12);

      for (int it = 0; it < 8; it++) begin
         do_load(int'($urandom_range(0, 3)), int'($urandom_range(0, 110)), 0, bit'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) != 0) do_swap();
         for (int k = 0; k < 4; k++) do_read(int'($urandom_range(0, 18)));
      end

`ifdef QUAN_E_OOB_ERR_EN
      do_read(17);
      chk("err_oob_set", err_oob, 1'b1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
